vga_sync_rx: RTL and testbench

Timing recovery block for the VGA interface: consumes the active-low `h_sync`/`v_sync` pair produced by the 640x480@60 sync generator and regenerates pixel coordinates, an active-video flag and a lock indication. It sits on the capture/monitor side of the video path in the CLK25 domain and provides a self-check of the generator and a coordinate source for downstream pixel consumers. Both sync inputs are synchronous to CLK25; no synchronizer stage is used.

---
 rtl/vga_sync_rx.sv | 165 ++++++++++++++++
 tb/tb_vga_sync_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// VGA timing recovery: rebuilds x/y, active video and lock status from the h_sync/v_sync pair.
// Define VGA_RX_MEASURE_EN to build the line-length / frame-height measurement; otherwise both read 0.
//
// state   | meaning
// SEARCH  | not aligned, waiting for a v_sync fall; errors ignored
// ACQUIRE | aligned, counting clean frames toward lock
// LOCKED  | stable timing, active/frame_start enabled
module vga_sync_rx #(
   parameter int H_TOTAL     = 800,
   parameter int H_ACTIVE    = 640,
   parameter int H_FALL      = 655,
   parameter int V_TOTAL     = 525,
   parameter int V_ACTIVE    = 480,
   parameter int V_FALL      = 489,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       CLK25,
   input  logic       Reset,
   input  logic       h_sync,
   input  logic       v_sync,
   output logic [9:0] rx_x,
   output logic [9:0] rx_y,
   output logic       active,
   output logic       frame_start,
   output logic       locked,
   output logic [7:0] err_cnt,
   output logic [9:0] line_len,
   output logic [9:0] frame_lines
);

   localparam logic [9:0]  X_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  X_FALL = 10'(H_FALL);
   localparam logic [9:0]  Y_FALL = 10'(V_FALL);
   localparam logic [9:0]  X_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0]  Y_ACT  = 10'(V_ACTIVE);
   localparam logic [10:0] TO_LIM = 11'(2 * H_TOTAL);
   localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   state_t      state, state_nx;
   logic        h_q, v_q;
   logic        hfall, vfall;
   logic        x_wrap;
   logic [9:0]  x_pred, y_pred, x_nx, y_nx;
   logic [10:0] to_cnt;
   logic        h_err, v_err, to_err, any_err;
   logic [3:0]  good, good_nx;
   logic [7:0]  err_nx;

   always_comb begin
      hfall  = h_q & ~h_sync;
      vfall  = v_q & ~v_sync;
      x_wrap = (rx_x == X_LAST);
      x_pred = x_wrap ? 10'd0 : rx_x + 10'd1;
      if (x_wrap)
         y_pred = (rx_y == Y_LAST) ? 10'd0 : rx_y + 10'd1;
      else
         y_pred = rx_y;
      x_nx    = hfall ? X_FALL : x_pred;
      y_nx    = vfall ? Y_FALL : y_pred;
      h_err   = hfall && (x_pred != X_FALL);
      v_err   = vfall && (y_pred != Y_FALL);
      // Fires once, on the cycle the counter would step onto the limit.
      to_err  = !hfall && (to_cnt == TO_LIM - 11'd1);
      any_err = h_err | v_err | to_err;

      state_nx = state;
      good_nx  = good;
      err_nx   = err_cnt;
      case (state)
         SEARCH: begin
            if (vfall) begin
               state_nx = ACQUIRE;
               good_nx  = 4'd0;
            end
         end
         ACQUIRE: begin
            if (any_err) begin
               state_nx = SEARCH;
               good_nx  = 4'd0;
               err_nx   = (err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1;
            end else if (vfall) begin
               good_nx = good + 4'd1;
               if (good_nx == LOCK_N)
                  state_nx = LOCKED;
            end
         end
         LOCKED: begin
            if (any_err) begin
               state_nx = SEARCH;
               good_nx  = 4'd0;
               err_nx   = (err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1;
            end
         end
         default: begin
            state_nx = SEARCH;
            good_nx  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge CLK25 or posedge Reset) begin
      if (Reset) begin
         state       <= SEARCH;
         h_q         <= 1'b1;
         v_q         <= 1'b1;
         rx_x        <= 10'd0;
         rx_y        <= 10'd0;
         to_cnt      <= 11'd0;
         good        <= 4'd0;
         err_cnt     <= 8'd0;
         locked      <= 1'b0;
         active      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nx;
         h_q         <= h_sync;
         v_q         <= v_sync;
         rx_x        <= x_nx;
         rx_y        <= y_nx;
         good        <= good_nx;
         err_cnt     <= err_nx;
         if (hfall)
            to_cnt <= 11'd0;
         else if (to_cnt != TO_LIM)
            to_cnt <= to_cnt + 11'd1;
         // Outputs are built from next-state values so they line up with rx_x/rx_y.
         locked      <= (state_nx == LOCKED);
         active      <= (state_nx == LOCKED) && (x_nx < X_ACT) && (y_nx < Y_ACT);
         frame_start <= (state_nx == LOCKED) && (x_nx == 10'd0) && (y_nx == 10'd0);
      end
   end

`ifdef VGA_RX_MEASURE_EN
   logic [9:0] per_cnt, ln_cnt;

   always_ff @(posedge CLK25 or posedge Reset) begin
      if (Reset) begin
         per_cnt     <= 10'd0;
         ln_cnt      <= 10'd0;
         line_len    <= 10'd0;
         frame_lines <= 10'd0;
      end else begin
         if (hfall) begin
            per_cnt  <= 10'd0;
            line_len <= per_cnt + 10'd1;
         end else begin
            per_cnt  <= per_cnt + 10'd1;
         end
         if (vfall) begin
            ln_cnt      <= 10'd0;
            frame_lines <= ln_cnt;
         end else if (hfall) begin
            ln_cnt      <= ln_cnt + 10'd1;
         end
      end
   end
`else
   assign line_len    = 10'd0;
   assign frame_lines = 10'd0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx on a shrunken 20x12 raster; expected events and samples are queued
// by the stimulus process and consumed by an independent negedge monitor.
module tb_vga_sync_rx;
   localparam int HT = 20, HA = 12, HF = 14, HSW = 3;
   localparam int VT = 12, VA = 8, VF = 9, VSW = 2;
   localparam int LF = 2;
   localparam int N_CYC = 3200;
`ifdef VGA_RX_MEASURE_EN
   localparam int MEAS = 1;
`else
   localparam int MEAS = 0;
`endif

   logic       CLK25 = 1'b0;
   logic       Reset = 1'b1;
   logic       h_sync = 1'b1;
   logic       v_sync = 1'b1;
   logic [9:0] rx_x, rx_y, line_len, frame_lines;
   logic       active, frame_start, locked;
   logic [7:0] err_cnt;

   vga_sync_rx #(
      .H_TOTAL(HT), .H_ACTIVE(HA), .H_FALL(HF),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_FALL(VF), .LOCK_FRAMES(LF)
   ) dut (
      .CLK25(CLK25), .Reset(Reset), .h_sync(h_sync), .v_sync(v_sync),
      .rx_x(rx_x), .rx_y(rx_y), .active(active), .frame_start(frame_start),
      .locked(locked), .err_cnt(err_cnt), .line_len(line_len), .frame_lines(frame_lines)
   );

   always #20 CLK25 = ~CLK25;

   typedef struct { int cyc; string name; int sel; int exp; } chk_t;
   typedef struct { int cyc; string name; } ev_t;

   chk_t chk_q[$];
   ev_t  ev_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   act_cnt = 0;
   int   p = 0, sx = 0, sy = 0;
   bit   h_shift = 0, h_supp = 0;
   bit   locked_q = 0;

   function automatic int dut_val(int sel);
      case (sel)
         0: return int'(rx_x);
         1: return int'(rx_y);
         2: return int'(active);
         3: return int'(frame_start);
         4: return int'(locked);
         5: return int'(err_cnt);
         6: return int'(line_len);
         7: return int'(frame_lines);
         default: return act_cnt;
      endcase
   endfunction

   task automatic push_chk(string n, int sel, int e);
      chk_t c;
      c.cyc = cyc; c.name = n; c.sel = sel; c.exp = e;
      chk_q.push_back(c);
   endtask

   task automatic push_ev(int c, string n);
      ev_t e;
      e.cyc = c; e.name = n;
      ev_q.push_back(e);
   endtask

   task automatic push_zero(string tag);
      push_chk({tag, "_rx_x"}, 0, 0);
      push_chk({tag, "_rx_y"}, 1, 0);
      push_chk({tag, "_active"}, 2, 0);
      push_chk({tag, "_frame_start"}, 3, 0);
      push_chk({tag, "_locked"}, 4, 0);
      push_chk({tag, "_err_cnt"}, 5, 0);
      push_chk({tag, "_line_len"}, 6, 0);
      push_chk({tag, "_frame_lines"}, 7, 0);
   endtask

   task automatic drive_sync();
      bit h_lo;
      sx = p % HT;
      sy = (p / HT) % VT;
      h_lo = (sx >= HF) && (sx < HF + HSW);
      if (h_shift) h_lo = (sx >= HF + 2) && (sx < HF + 2 + HSW);
      if (h_supp)  h_lo = 1'b0;
      h_sync = ~h_lo;
      v_sync = ~((sy >= VF) && (sy < VF + VSW));
   endtask

   // Stimulus: the generator shows position p = cyc, sampled by the DUT on edge cyc+1.
   initial begin
      // Hand-computed event cycles (frame = 240 clocks, first v_sync fall at p=180).
      push_ev(661,  "lock_rise");
      push_ev(721,  "frame_start");
      push_ev(961,  "frame_start");
      push_ev(1017, "lock_fall");
      push_ev(1621, "lock_rise");
      push_ev(1681, "frame_start");
      push_ev(1775, "lock_fall");
      push_ev(2341, "lock_rise");
      push_ev(2401, "frame_start");
      push_ev(2500, "lock_fall");
      push_ev(3061, "lock_rise");
      push_ev(3121, "frame_start");

      p = 0;
      drive_sync();
      repeat (3) @(posedge CLK25);
      #1;
      push_zero("reset");
      @(negedge CLK25);
      #5 Reset = 1'b0;

      for (int n = 1; n <= N_CYC; n++) begin
         @(posedge CLK25);
         #1;
         cyc = n;
         if (n == 200 || n == 800 || n == 3100) begin
            push_chk("rx_x_vs_gen", 0, sx);
            push_chk("rx_y_vs_gen", 1, sy);
         end
         if (n == 200)  push_chk("line_len", 6, MEAS ? HT : 0);
         if (n == 500) begin
            push_chk("frame_lines", 7, MEAS ? VT : 0);
            push_chk("locked_acquiring", 4, 0);
            push_chk("err_cnt_clean", 5, 0);
         end
         if (n == 800) begin
            push_chk("locked_clean", 4, 1);
            push_chk("err_cnt_locked", 5, 0);
         end
         if (n == 961)  push_chk("active_per_frame", 8, HA * VA);
         if (n == 1017) begin
            push_chk("err_cnt_hshift", 5, 1);
            push_chk("locked_hshift", 4, 0);
         end
         if (n == 1775) push_chk("err_cnt_timeout", 5, 2);
         if (n == 2500) begin
            Reset = 1'b1;
            push_zero("midreset");
         end
         if (n == 2502) Reset = 1'b0;
         if (n == 3100) begin
            push_chk("err_cnt_after_reset", 5, 0);
            push_chk("locked_after_reset", 4, 1);
            push_chk("line_len_late", 6, MEAS ? HT : 0);
         end
         p = n;
         h_shift = (p >= 1000) && (p < 1020);
         h_supp  = (p >= 1740) && (p < 1780);
         drive_sync();
      end

      @(negedge CLK25);
      #1;
      while (ev_q.size() > 0) begin
         ev_t e;
         e = ev_q.pop_front();
         checks++;
         failures++;
         $display("FAIL missing_event %s: expected at cycle %0d, never seen", e.name, e.cyc);
      end
      while (chk_q.size() > 0) begin
         chk_t c;
         c = chk_q.pop_front();
         checks++;
         failures++;
         $display("FAIL unchecked_sample %s at cycle %0d", c.name, c.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic take_event(string n);
      ev_t e;
      checks++;
      if (ev_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event %s at cycle %0d (none expected)", n, cyc);
      end else begin
         e = ev_q.pop_front();
         if (e.name != n || e.cyc != cyc) begin
            failures++;
            $display("FAIL event_%s: got %s at cycle %0d, expected %s at cycle %0d",
                     e.name, n, cyc, e.name, e.cyc);
         end
      end
   endtask

   // Monitor: compares queued expectations against DUT outputs on the falling edge.
   initial begin
      forever begin
         @(negedge CLK25);
         while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            chk_t c;
            int   v;
            c = chk_q.pop_front();
            v = dut_val(c.sel);
            checks++;
            if (c.cyc != cyc || v != c.exp) begin
               failures++;
               $display("FAIL %s: cycle %0d got %0d, expected %0d (due cycle %0d)",
                        c.name, cyc, v, c.exp, c.cyc);
            end
         end
         if (locked && !locked_q) take_event("lock_rise");
         if (!locked && locked_q) take_event("lock_fall");
         if (frame_start) begin
            take_event("frame_start");
            checks++;
            if (!active) begin
               failures++;
               $display("FAIL frame_start_active: cycle %0d active=%0d, expected 1", cyc, active);
            end
         end
         locked_q = locked;
         if (frame_start) act_cnt = active ? 1 : 0;
         else if (active) act_cnt++;
      end
   end

endmodule
